// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//  - Register select values decoded from addr[3:2]
//  - STATUS register bit positions
//  - Transmit FSM state encoding
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-TCM style bus between the CPU (master) and a memory-mapped responder.
//  en      access strobe (read or write)
//  wen     byte write enables, all zero for a read
//  addr    byte address
//  data_i  write data toward the responder
//  data_o  read data from the responder, registered one cycle after the access
interface mmio_uart_tx_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output en, wen, addr, data_i, input data_o);
    modport slave  (input en, wen, addr, data_i, output data_o);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO for the UART transmit path.
//  clk, reset_n   clock, asynchronous active-low reset (pointers/count only)
//  push, din      write request and data; ignored when full
//  pop, dout      read request; dout shows the head entry combinationally
//  full, empty    occupancy flags
//  count          number of stored entries (log2(DEPTH)+1 bits)
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty are judged on the state before this edge, so a push while
    // full is dropped even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-TCM bus.
//  clk      system clock
//  reset_n  asynchronous active-low reset; aborts any frame, tx_o goes high
//  bus      slave side of the data-TCM bus (en/wen/addr/data_i/data_o)
//  tx_o     serial line, idle high
//  irq_o    high when the FIFO is empty and no frame is in flight
// Registers (addr[3:2]): TXDATA push, STATUS, BAUDDIV, reserved.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [3:0]  BASE_NIB    = 4'hA,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic           clk,
    input  logic           reset_n,
    mmio_uart_tx_if.slave  bus,
    output logic           tx_o,
    output logic           irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [3:0] sat4(input logic [CW-1:0] c);
        int v;
        v = int'(c);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    logic           hit;
    logic [1:0]     reg_sel;
    logic           rd_acc;
    logic           wr_txdata;
    logic           wr_ovf_clr;
    logic           overflow;
    logic [15:0]    baud_div;
    logic [15:0]    cur_div;
    logic [15:0]    baud_cnt;
    logic           tick;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic [31:0]    rdata;
    uart_tx_state_t state;

    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           busy;
    logic           unused_bits;

    assign unused_bits = ^{bus.addr[27:4], bus.addr[1:0], bus.data_i[31:16]};

    assign hit        = bus.en && (bus.addr[31:28] == BASE_NIB);
    assign reg_sel    = bus.addr[3:2];
    assign rd_acc     = hit && (bus.wen == 4'b0000);
    assign wr_txdata  = hit && (reg_sel == REG_TXDATA) && bus.wen[0];
    assign wr_ovf_clr = hit && (reg_sel == REG_STATUS) && bus.wen[0] && bus.data_i[ST_OVF];

    assign busy  = (state != IDLE);
    assign irq_o = fifo_empty && !busy;

    // Each bit runs against the divisor latched at its start, so a BAUDDIV
    // write only affects bits that begin after it.
    assign tick = (baud_cnt == cur_div);

    // Head is taken when leaving IDLE or at the end of STOP with data waiting.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && tick));

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_txdata),
        .din     (bus.data_i[7:0]),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata[ST_FULL]                 = fifo_full;
                rdata[ST_EMPTY]                = fifo_empty;
                rdata[ST_BUSY]                 = busy;
                rdata[ST_OVF]                  = overflow;
                rdata[ST_CNT_LSB+3:ST_CNT_LSB] = sat4(fifo_count);
            end
            REG_BAUDDIV: rdata[15:0] = baud_div;
            default:     rdata = '0;
        endcase
    end

    // Bus side: registered read data, sticky overflow, divider register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_o <= '0;
            overflow   <= 1'b0;
            baud_div   <= DEFAULT_DIV;
        end else begin
            bus.data_o <= rd_acc ? rdata : 32'd0;
            if (wr_txdata && fifo_full) overflow <= 1'b1;
            else if (wr_ovf_clr)        overflow <= 1'b0;
            if (hit && (reg_sel == REG_BAUDDIV)) begin
                if (bus.wen[0]) baud_div[7:0]  <= bus.data_i[7:0];
                if (bus.wen[1]) baud_div[15:8] <= bus.data_i[15:8];
            end
        end
    end

    // Transmit FSM, baud counter, bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            baud_cnt <= '0;
            cur_div  <= DEFAULT_DIV;
            bit_cnt  <= '0;
        end else begin
            baud_cnt <= tick ? 16'd0 : baud_cnt + 16'd1;
            if (tick) cur_div <= baud_div;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        state   <= START;
                        tx_o    <= 1'b0;
                        cur_div <= baud_div;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx_o    <= shift[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_o    <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!fifo_empty) begin
                            state <= START;
                            tx_o  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

    // Shift register: loaded on pop, shifted LSB-first as each data bit ends
    always_ff @(posedge clk) begin
        if (fifo_pop)
            shift <= fifo_dout;
        else if ((state == DATA) && tick && (bit_cnt != 3'd7))
            shift <= {1'b0, shift[7:1]};
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX   = 32'hA000_0000;
    localparam logic [31:0] A_ST   = 32'hA000_0004;
    localparam logic [31:0] A_BAUD = 32'hA000_0008;
    localparam logic [31:0] A_RSV  = 32'hA000_000C;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx_o, irq_o;
    always #5 clk = ~clk;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_NIB(4'hA), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd867)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bit_p = 868;
    bit          mon_en = 1'b1;
    logic        rd_seen = 1'b0;
    logic [15:0] model_div = 16'd867;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [31:0] rd_q[$];
    string       rd_nm[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_seen <= bus.en && (bus.wen == 4'b0000);
    end

    // Read-data monitor: every read access is answered on data_o one cycle later
    initial begin : rd_mon
        logic [31:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", bus.data_o, 32'hDEAD_BEEF);
                end else begin
                    e  = rd_q.pop_front();
                    nm = rd_nm.pop_front();
                    chk(nm, bus.data_o, e);
                end
            end
        end
    end

    // Serial-line monitor: each frame must be 0, 8 data bits LSB-first, 1,
    // every level held exactly bit_p clocks.
    initial begin : tx_mon
        int p, errs;
        bit had_exp;
        logic [7:0] eb, got;
        logic [9:0] frame;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && tx_o === 1'b0) begin
                p = bit_p;
                start_q.push_back(cyc);
                had_exp = (exp_q.size() != 0);
                eb = had_exp ? exp_q.pop_front() : 8'h00;
                frame = {1'b1, eb, 1'b0};
                errs = 0;
                got = '0;
                for (int n = 0; n < 10 * p; n++) begin
                    if (n > 0) @(negedge clk);
                    if (tx_o !== frame[n / p]) errs++;
                    if ((n % p) == (p / 2) && (n / p) >= 1 && (n / p) <= 8) got[(n / p) - 1] = tx_o;
                end
                n_chk++;
                if (!had_exp || errs != 0) begin
                    n_fail++;
                    $display("FAIL frame: got byte 0x%02h (%0d bad clocks, expected=%0d), expected 0x%02h",
                             got, errs, had_exp, eb);
                end
            end
        end
    end

    task automatic put(input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.en = e; bus.wen = w; bus.addr = a; bus.data_i = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk); put(1'b1, w, a, d);
        @(negedge clk); put(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk); put(1'b1, 4'h0, a, 32'h0);
        rd_q.push_back(exp); rd_nm.push_back(nm);
        @(negedge clk); put(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic set_div(input logic [15:0] d);
        wr(A_BAUD, {16'h0, d}, 4'b0011);
        model_div = d;
        bit_p = int'(d) + 1;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (irq_o !== 1'b1 && c < bound) begin
            @(negedge clk); c++;
        end
        if (c >= bound) chk("idle_timeout", {31'h0, irq_o}, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int c, errs, seg, lvl;
        logic [31:0] d;
        logic wave[80];
        put(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'h0, tx_o}, 32'h1);
        chk("rst_irq", {31'h0, irq_o}, 32'h1);
        chk("rst_data_o", bus.data_o, 32'h0);
        reset_n = 1'b1;

        // Reset values and decode
        rd(A_ST, 32'h2, "status_rst");
        rd(A_BAUD, 32'h363, "baud_rst");
        rd(A_RSV, 32'h0, "rsvd_rd");
        rd(A_TX, 32'h0, "txdata_rd");
        rd(32'h1000_0004, 32'h0, "nonhit_rd");

        // Byte-granular divider writes
        wr(A_BAUD, 32'hFFFF_1234, 4'hF); model_div = 16'h1234;
        rd(A_BAUD, {16'h0, model_div}, "baud_full_wr");
        wr(A_BAUD, 32'h0000_AB00, 4'b0010); model_div[15:8] = 8'hAB;
        rd(A_BAUD, {16'h0, model_div}, "baud_byte1_wr");
        wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        rd(A_RSV, 32'h0, "rsvd_after_wr");
        wr(32'h5000_0000, 32'h77, 4'h1);
        rd(A_ST, 32'h2, "status_after_nonhit");

        // Single 0x55 frame at 4 clk/bit with irq timing
        set_div(16'd3);
        exp_q.push_back(8'h55);
        wr(A_TX, 32'h55, 4'h1);
        chk("irq_low_in_frame", {31'h0, irq_o}, 32'h0);
        c = 0;
        while (irq_o !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        chk("irq_rise_cycles", c, 41);
        repeat (3) @(negedge clk);

        // Back-to-back frames with no idle gap
        start_q.delete();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        @(negedge clk); put(1'b1, 4'h1, A_TX, 32'hA5);
        @(negedge clk); put(1'b1, 4'h1, A_TX, 32'h3C);
        @(negedge clk); put(1'b0, 4'h0, 32'h0, 32'h0);
        wait_idle(200);
        chk("b2b_frames", start_q.size(), 2);
        if (start_q.size() >= 2) chk("b2b_gap", start_q[1] - start_q[0], 10 * bit_p);

        // Five pushes fill the FIFO behind the first frame; the sixth overflows
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            if (i < 5) exp_q.push_back(d[7:0]);
            @(negedge clk); put(1'b1, 4'h1, A_TX, d);
        end
        @(negedge clk); put(1'b1, 4'h0, A_ST, 32'h0);
        rd_q.push_back(32'h4D); rd_nm.push_back("status_overflow");
        @(negedge clk); put(1'b0, 4'h0, 32'h0, 32'h0);
        wr(A_ST, 32'h8, 4'h1);
        rd(A_ST, 32'h45, "status_ovf_cleared");
        wait_idle(400);

        // Divider change mid data bit: current bit keeps the old period
        mon_en = 1'b0;
        wr(A_TX, 32'h55, 4'h1);
        c = 0;
        while (tx_o !== 1'b0 && c < 50) begin @(negedge clk); c++; end
        chk("t5_start_seen", {31'h0, tx_o}, 32'h0);
        for (int n = 0; n < 80; n++) begin
            if (n > 0) @(negedge clk);
            wave[n] = tx_o;
            if (n == 5) put(1'b1, 4'b0011, A_BAUD, 32'h7);
            if (n == 6) put(1'b0, 4'h0, 32'h0, 32'h0);
        end
        model_div = 16'd7; bit_p = 8;
        for (int s = 0; s < 10; s++) begin
            errs = 0;
            for (int n = 0; n < 80; n++) begin
                if (n < 4)       begin seg = 0; lvl = 0; end
                else if (n < 8)  begin seg = 1; lvl = 1; end
                else if (n < 64) begin seg = 2 + (n - 8) / 8; lvl = (((n - 8) / 8 + 1) % 2 == 0) ? 1 : 0; end
                else             begin seg = 9; lvl = 1; end
                if (seg == s && wave[n] !== lvl[0]) errs++;
            end
            chk($sformatf("t5_seg%0d_bad_clocks", s), errs, 0);
        end
        wait_idle(200);

        // Reset in the middle of a frame
        wr(A_TX, 32'h00, 4'h1);
        wr(A_TX, 32'h00, 4'h1);
        c = 0;
        while (tx_o !== 1'b0 && c < 50) begin @(negedge clk); c++; end
        repeat (12) @(negedge clk);
        chk("t6_tx_low_before_rst", {31'h0, tx_o}, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_tx_async_high", {31'h0, tx_o}, 32'h1);
        chk("t6_irq_in_rst", {31'h0, irq_o}, 32'h1);
        @(negedge clk); reset_n = 1'b1;
        model_div = 16'd867;
        rd(A_ST, 32'h2, "t6_status_after_rst");
        rd(A_BAUD, {16'h0, model_div}, "t6_baud_after_rst");
        c = 0;
        for (int n = 0; n < 30; n++) begin @(negedge clk); if (tx_o !== 1'b1) c++; end
        chk("t6_line_idle_after_rst", c, 0);
        mon_en = 1'b1;

        // Randomised bursts at several divisors including the 1 clk/bit limit
        for (int it = 0; it < 6; it++) begin
            set_div((it == 0) ? 16'd0 : 16'($urandom_range(1, 5)));
            c = $urandom_range(1, 4);
            for (int b = 0; b < c; b++) begin
                d = $urandom;
                exp_q.push_back(d[7:0]);
                @(negedge clk); put(1'b1, 4'h1, A_TX, d);
            end
            @(negedge clk); put(1'b0, 4'h0, 32'h0, 32'h0);
            wait_idle(c * 10 * bit_p + 50);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("frames_outstanding", exp_q.size(), 0);
        chk("reads_outstanding", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
